// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited word requests, in-order responses into a DEPTH-entry prefetch FIFO.
// Optional FETCH_MISALIGN_TRAP_EN adds a sticky o_Misaligned trap on unaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH         = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectAddress,
  output logic        o_MemReqValid,
  input  logic        i_MemReqReady,
  output logic [31:0] o_MemReqAddress,
  input  logic        i_MemRespValid,
  input  logic [31:0] i_MemRespData,
  output logic        o_InstValid,
  input  logic        i_InstReady,
  output logic [31:0] o_InstWord,
  output logic [31:0] o_InstAddress
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        o_Misaligned
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } entry_t;

  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            resp_pc_q, resp_pc_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  entry_t [DEPTH-1:0]     fifo_q, fifo_d;
  logic                   trap_q;
  logic [CW:0]            used;
  logic                   req_fire, resp_fire, push, pop;
  logic [31:0]            redir_pc;
  entry_t                 head;
  logic                   unused_redir_lsbs;

  assign redir_pc          = {i_RedirectAddress[31:2], 2'b00};
  assign unused_redir_lsbs = ^i_RedirectAddress[1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_d;
  assign o_Misaligned = trap_q;
`else
  assign trap_q = 1'b0;
`endif

  // drop <= inflight always holds, so this never underflows
  assign used = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};

  assign o_MemReqValid   = i_Reset && !i_Redirect && !trap_q && (used < (CW+1)'(DEPTH));
  assign o_MemReqAddress = fetch_pc_q;
  assign head            = fifo_q[rd_ptr_q];
  assign o_InstValid     = (count_q != '0);
  assign o_InstWord      = head.word;
  assign o_InstAddress   = head.addr;

  assign req_fire  = o_MemReqValid && i_MemReqReady;
  assign resp_fire = i_MemRespValid && (inflight_q != '0);
  assign pop       = o_InstValid && i_InstReady;
  assign push      = resp_fire && (drop_q == '0) && !i_Redirect && !trap_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_d     = fifo_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d     = trap_q;
`endif
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (resp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: resp_pc_q, word: i_MemRespData};
      wr_ptr_d         = wr_ptr_q + 1'b1;
      resp_pc_d        = resp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Everything still outstanding after this edge belongs to the old path
    if (i_Redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = inflight_d;
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_d     = (i_RedirectAddress[1:0] != 2'b00);
`endif
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      fetch_pc_q <= RESET_ADDRESS;
      resp_pc_q  <= RESET_ADDRESS;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_q     <= fifo_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= trap_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect traffic against a queue-based model,
// plus directed scenarios with literal expectations.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        i_Clock, i_Reset, i_Redirect, i_MemReqReady, i_MemRespValid, i_InstReady;
  logic [31:0] i_RedirectAddress, i_MemRespData;
  logic        o_MemReqValid, o_InstValid;
  logic [31:0] o_MemReqAddress, o_InstWord, o_InstAddress;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_Misaligned;
`endif

  fetch_unit #(.RESET_ADDRESS(32'h0), .DEPTH(DEPTH)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Redirect(i_Redirect),
    .i_RedirectAddress(i_RedirectAddress), .o_MemReqValid(o_MemReqValid),
    .i_MemReqReady(i_MemReqReady), .o_MemReqAddress(o_MemReqAddress),
    .i_MemRespValid(i_MemRespValid), .i_MemRespData(i_MemRespData),
    .o_InstValid(o_InstValid), .i_InstReady(i_InstReady),
    .o_InstWord(o_InstWord), .o_InstAddress(o_InstAddress)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .o_Misaligned(o_Misaligned)
`endif
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    bit          drop;
  } mreq_t;

  // Model: outstanding memory requests, expected FIFO contents, fetch PC, trap flag
  mreq_t       memq[$];
  logic [31:0] fq_addr[$], fq_word[$];
  logic [31:0] fpc;
  bit          mis;
  int          cyc, lat_min, lat_max, first_valid;
  logic [31:0] acc_log[$], pop_log[$], popw_log[$];
  int          n_total, n_pass;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int kept();
    int k = 0;
    foreach (memq[i]) if (!memq[i].drop) k++;
    return k;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step(input bit redir, input logic [31:0] raddr, input bit mready,
                      input bit iready, input bit resp_en, input bit spur);
    bit    exp_rv, acc, resp, pop;
    mreq_t e;
    resp = (memq.size() != 0) && (memq[0].rdy <= cyc) && resp_en;
    i_Redirect        = redir;
    i_RedirectAddress = raddr;
    i_MemReqReady     = mready;
    i_InstReady       = iready;
    i_MemRespValid    = resp || (spur && memq.size() == 0);
    i_MemRespData     = resp ? memword(memq[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !redir && !mis && (fq_addr.size() + kept()) < DEPTH;
    chk("req_valid", o_MemReqValid, exp_rv);
    if (exp_rv) chk("req_addr", o_MemReqAddress, fpc);
    chk("inst_valid", o_InstValid, fq_addr.size() != 0);
    if (fq_addr.size() != 0) begin
      chk("inst_addr", o_InstAddress, fq_addr[0]);
      chk("inst_word", o_InstWord, fq_word[0]);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misaligned", o_Misaligned, mis);
`endif
    if (o_InstValid && first_valid < 0) first_valid = cyc;
    if (o_MemReqValid && mready) acc_log.push_back(o_MemReqAddress);
    if (o_InstValid && iready && !redir) begin
      pop_log.push_back(o_InstAddress);
      popw_log.push_back(o_InstWord);
    end
    acc = exp_rv && mready;
    pop = (fq_addr.size() != 0) && iready;
    if (resp) e = memq.pop_front();
    if (redir) begin
      fq_addr.delete();
      fq_word.delete();
      foreach (memq[i]) memq[i].drop = 1'b1;
      fpc = raddr & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis = (raddr[1:0] != 2'b00);
`endif
    end else begin
      if (pop) begin
        void'(fq_addr.pop_front());
        void'(fq_word.pop_front());
      end
      if (resp && !e.drop && !mis) begin
        fq_addr.push_back(e.addr);
        fq_word.push_back(memword(e.addr));
      end
    end
    if (acc) begin
      e.addr = fpc;
      e.rdy  = cyc + $urandom_range(lat_max, lat_min);
      e.drop = 1'b0;
      memq.push_back(e);
      fpc = fpc + 32'd4;
    end
    @(posedge i_Clock);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (memq.size() == 0 && fq_addr.size() == 0) done = 1;
      else step(0, 0, 0, 1, 1, 0);
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    n_total = 0; n_pass = 0; cyc = 0; fpc = 32'h0; mis = 0;
    lat_min = 1; lat_max = 1; first_valid = -1;
    i_Reset = 0; i_Redirect = 0; i_RedirectAddress = 0; i_MemReqReady = 1;
    i_MemRespValid = 0; i_MemRespData = 0; i_InstReady = 1;
    repeat (2) @(posedge i_Clock);
    #1;
    chk("rst_req_valid", o_MemReqValid, 0);
    chk("rst_req_addr", o_MemReqAddress, 32'h0);
    chk("rst_inst_valid", o_InstValid, 0);
    chk("rst_inst_word", o_InstWord, 0);
    chk("rst_inst_addr", o_InstAddress, 0);
    i_Reset = 1;

    // T1: streaming, 1-cycle memory
    repeat (8) step(0, 0, 1, 1, 1, 0);
    chk("t1_first_valid", first_valid, 2);
    chk("t1_pop0", pop_log[0], 32'h0);
    chk("t1_pop1", pop_log[1], 32'h4);
    chk("t1_pop2", pop_log[2], 32'h8);

    // T2: decode stalled -> credit stops requests at DEPTH
    drain();
    step(1, 32'h1000, 1, 1, 1, 0);
    acc_log.delete();
    repeat (10) step(0, 0, 1, 0, 1, 0);
    chk("t2_accepts", acc_log.size(), 4);
    chk("t2_req_blocked", o_MemReqValid, 0);
    chk("t2_head", o_InstAddress, 32'h1000);
    pop_log.delete();
    repeat (8) step(0, 0, 1, 1, 1, 0);
    chk("t2_resume0", pop_log[0], 32'h1000);
    chk("t2_resume1", pop_log[1], 32'h1004);
    chk("t2_resume4", pop_log[4], 32'h1010);

    // T3: redirect with two slow responses in flight
    drain();
    lat_min = 3; lat_max = 3;
    step(1, 32'h80, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(1, 32'h100, 0, 1, 1, 0);
    pop_log.delete(); popw_log.delete();
    for (int i = 0; i < 30 && pop_log.size() == 0; i++) step(0, 0, 1, 1, 1, 0);
    chk("t3_first_addr", pop_log[0], 32'h100);
    chk("t3_first_word", popw_log[0], memword(32'h100));

    // T4: redirect coinciding with a response and a pop; then a stray response
    drain();
    lat_min = 1; lat_max = 1;
    step(1, 32'h400, 0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 0, 1, 0);
    step(1, 32'h500, 0, 1, 1, 0);
    chk("t4_flushed", o_InstValid, 0);
    repeat (6) step(0, 0, 1, 1, 1, 0);
    drain();
    step(0, 0, 0, 1, 0, 1);
    chk("t4_spur_inst", o_InstValid, 0);
    chk("t4_spur_req", o_MemReqValid, 1);
    repeat (8) step(0, 0, 1, 1, 1, 0);

    // T5: fetch PC wraps
    drain();
    step(1, 32'hFFFF_FFF8, 1, 1, 1, 0);
    acc_log.delete();
    repeat (4) step(0, 0, 1, 1, 1, 0);
    chk("t5_pre_wrap", acc_log[1], 32'hFFFF_FFFC);
    chk("t5_wrap", acc_log[2], 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
    // T6: misaligned trap and recovery
    step(1, 32'h102, 1, 1, 1, 0);
    chk("t6_trap", o_Misaligned, 1);
    chk("t6_no_req", o_MemReqValid, 0);
    repeat (3) step(0, 0, 1, 1, 1, 0);
    step(1, 32'h200, 1, 1, 1, 0);
    chk("t6_clear", o_Misaligned, 0);
    acc_log.delete();
    step(0, 0, 1, 1, 1, 0);
    chk("t6_refetch", acc_log[0], 32'h200);
`endif

    // Random traffic
    for (int blk = 0; blk < 15; blk++) begin
      lat_min = $urandom_range(3, 1);
      lat_max = lat_min + $urandom_range(4, 0);
      for (int i = 0; i < 200; i++) begin
        bit          rd;
        logic [31:0] ra;
        rd = ($urandom_range(24, 0) == 0);
        ra = $urandom;
        if ($urandom_range(7, 0) != 0) ra[1:0] = 2'b00;
        if ($urandom_range(9, 0) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
        step(rd, ra, $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
             $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
